// File: rtl/layer0_mac.sv
// Layer-0 multiply-accumulate stage: streams NUM_IN weight rows against NUM_IN
// pixels into NUM_OUT parallel 32-bit accumulators, then registers ReLU'd results.
module layer0_mac #(
  parameter int NUM_IN  = 784,
  parameter int NUM_OUT = 128,
  parameter int FRAC    = 16,
  parameter int ADDR_W  = $clog2(NUM_IN)
) (
  input  logic                   clka,
  input  logic                   rst,
  input  logic                   start,
  output logic                   w_start,
  input  logic [NUM_OUT*32-1:0]  w_values,
  output logic [ADDR_W-1:0]      pix_addr,
  input  logic [31:0]            pix_data,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_OUT*32-1:0]  act
);

  typedef enum logic [1:0] {IDLE, REQ, RUN, FIN} state_t;

  localparam logic [ADDR_W:0]   LAST_ROW  = (ADDR_W+1)'(NUM_IN - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_IN - 1);

  state_t             state;
  logic [ADDR_W:0]    counter;
  logic [31:0]        acc  [NUM_OUT];
  logic [31:0]        term [NUM_OUT];
  logic signed [63:0] prod [NUM_OUT];

  // Full 64-bit signed product; keep bits [31+FRAC:FRAC] (floor shift).
  always_comb begin
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      prod[i] = $signed(w_values[i*32 +: 32]) * $signed(pix_data);
      term[i] = 32'(prod[i] >>> FRAC);
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= '0;
      act      <= '0;
      w_start  <= 1'b0;
      pix_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int unsigned i = 0; i < NUM_OUT; i++) acc[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= REQ;
            w_start  <= 1'b1;
            pix_addr <= '0;
            busy     <= 1'b1;
            counter  <= '0;
            for (int unsigned i = 0; i < NUM_OUT; i++) acc[i] <= '0;
          end
        end
        REQ: begin
          w_start  <= 1'b0;
          pix_addr <= ADDR_W'(1);
          state    <= RUN;
        end
        RUN: begin
          for (int unsigned i = 0; i < NUM_OUT; i++) acc[i] <= acc[i] + term[i];
          counter <= counter + 1'b1;
          // Address parks on the last pixel instead of wrapping past the end.
          if (pix_addr != LAST_ADDR) pix_addr <= pix_addr + 1'b1;
          if (counter == LAST_ROW) state <= FIN;
        end
        FIN: begin
          for (int unsigned i = 0; i < NUM_OUT; i++)
            act[i*32 +: 32] <= acc[i][31] ? '0 : acc[i];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
